// File: rtl/tbec_pkg.sv
// Shared widths and controller state encoding for the tbec memory slice.
package tbec_pkg;

  localparam int unsigned TBEC_ADDR_W = 8;
  localparam int unsigned TBEC_DATA_W = 32;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    WR      = 3'd2,
    RD      = 3'd3,
    RD_WAIT = 3'd4,
    RSP     = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/tbec_memory.sv
// Single-port synchronous RAM: write on we, registered read of addr every cycle.
module tbec_memory
  import tbec_pkg::*;
#(
  parameter int unsigned ADDR_W = TBEC_ADDR_W,
  parameter int unsigned DATA_W = TBEC_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and read-first registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data_in;
    end
    data_out <= mem[addr];
  end

endmodule

// File: rtl/tbec_mem_ctrl.sv
// Request controller in front of tbec_memory: init sweep after reset, then
// one-at-a-time read/write servicing with valid/ready on both sides.
module tbec_mem_ctrl
  import tbec_pkg::*;
#(
  parameter int unsigned       ADDR_W   = TBEC_ADDR_W,
  parameter int unsigned       DATA_W   = TBEC_DATA_W,
  parameter int unsigned       DEPTH    = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  // One extra bit so the counter can reach DEPTH and mark the sweep finished.
  localparam int unsigned CNT_W = ADDR_W + 1;

  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              init_done_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_d;

  // State, sweep counter and all outputs registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      init_done   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      init_done   <= init_done_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_data_in <= mem_data_in_d;
    end
  end

  // Next state and next output values; outputs line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    init_done_d   = init_done;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_data_in_d = mem_data_in;

    case (state_q)
      INIT: begin
        if (cnt_q == CNT_W'(DEPTH)) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          init_done_d = 1'b1;
        end else begin
          mem_we_d      = 1'b1;
          mem_addr_d    = cnt_q[ADDR_W-1:0];
          mem_data_in_d = INIT_VAL;
          cnt_d         = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d   = 1'b0;
          mem_addr_d    = req_addr;
          mem_data_in_d = req_wdata;
          if (req_we) begin
            state_d  = WR;
            mem_we_d = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rsp_rdata_d = mem_data_out;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

endmodule

// File: doc/tbec_mem_ctrl.md
Name: tbec_mem_ctrl

Overview:
Request controller sitting directly upstream of tbec_memory: it owns the memory's we/addr/data_in port and returns read data from data_out.
- After reset, sweeps every memory word to a known value, so the data path never reads uninitialised contents.
- Afterwards, serialises client read/write requests using valid/ready handshakes on both the request and response sides.

Parameters:
ADDR_W, 8, memory address width (matches tbec_memory addr)
DATA_W, 32, data word width (matches tbec_memory data_in/data_out)
DEPTH, 2**ADDR_W, number of words swept at init
INIT_VAL, 0, value written to every word during init sweep

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  client request present
req_ready  output  1  controller accepts request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  read data available
rsp_ready  input  1  client consumes read data
rsp_rdata  output  DATA_W  read data
init_done  output  1  init sweep complete, sticky until rst
mem_we  output  1  to tbec_memory we
mem_addr  output  ADDR_W  to tbec_memory addr
mem_data_in  output  DATA_W  to tbec_memory data_in
mem_data_out  input  DATA_W  from tbec_memory data_out; synchronous read, valid the cycle after mem_addr is presented with mem_we=0

Behaviour:
- Reset values: all outputs are registered and reset to 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, mem_we=0, mem_addr=0, mem_data_in=0.
  - State=INIT, sweep counter=0.
- States: INIT, IDLE, WR, RD, RD_WAIT, RSP.
- INIT:
  - mem_we=1, mem_addr=counter, mem_data_in=INIT_VAL; counter increments each cycle.
  - After writing DEPTH-1 (DEPTH cycles total), go to IDLE; init_done=1 from the first IDLE cycle onward.
  - req_ready=0 throughout INIT.
- IDLE:
  - req_ready=1, mem_we=0.
  - On req_valid&req_ready, latch req_addr/req_wdata into the mem_* registers.
  - Go to WR if req_we=1, else RD.
- WR (1 cycle):
  - mem_we=1 with the latched addr/data; memory writes at the end of this cycle.
  - Then IDLE; writes produce no response.
- RD (1 cycle): mem_we=0, mem_addr=latched addr. Then RD_WAIT.
- RD_WAIT (1 cycle): capture mem_data_out into rsp_rdata. Then RSP.
- RSP:
  - rsp_valid=1, rsp_rdata held stable.
  - On rsp_ready, go to IDLE with rsp_valid=0 next cycle.
  - Backpressure is unlimited.
- Latencies:
  - Write accepted at cycle T: memory updated at end of T+1; next acceptance possible at T+2.
  - Read accepted at T: rsp_valid=1 at T+3 at the earliest.
- req_ready is 1 only in IDLE, so at most one transaction is in flight.
- mem_we=0 in every state except INIT and WR.
- Read-after-write: a read accepted at T+2 or later returns the data written at T.
- Address is full-range (2**ADDR_W); no out-of-range case. The INIT counter does not wrap beyond DEPTH-1.
- Reset mid-operation:
  - rst=1 in any state discards the in-flight request and drops rsp_valid/init_done the next cycle.
  - The sweep restarts from address 0.
- rsp_ready while rsp_valid=0 is ignored.
- req inputs are ignored while req_ready=0.

Decomposition:
- Shared package tbec_pkg:
  - TBEC_ADDR_W=8 and TBEC_DATA_W=32 constants.
  - ctrl_state_t enum (INIT, IDLE, WR, RD, RD_WAIT, RSP).
- No sub-module is needed; the sweep counter and FSM are inline.
- The bench instantiates tbec_mem_ctrl connected to tbec_memory.

Test Plan:
- Reset 2 cycles, release -> mem_we=1 for exactly 256 cycles, mem_addr 0x00..0xFF, mem_data_in=0x00000000; init_done=1 and req_ready=1 on the cycle after.
- Write 0x01=0xAABBCCDD, 0x02=0xBBCCDDEE, 0x07=0xFFAABBCC, then read 0x01 -> rsp_rdata=0xAABBCCDD, rsp_valid exactly 3 cycles after read acceptance.
- Read unwritten 0x55 after init -> rsp_rdata=0x00000000.
- Read 0x07 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata=0xFFAABBCC stable, req_ready=0 throughout; one-cycle rsp_ready -> IDLE, req_ready=1 next cycle.
- Write 0xFF=0x12345678 immediately followed by read 0xFF (back-to-back req_valid) -> read accepted 2 cycles after write, returns 0x12345678.
- Assert rst during RD_WAIT of a pending read -> rsp_valid never rises; sweep restarts at mem_addr=0x00; read of 0x01 after init_done returns 0x00000000.
